// File: rtl/shl_pkg.sv
// Shared types and constants for the sequential left shifter/rotator.
package shl_pkg;

   localparam int unsigned DW = 16;
   localparam int unsigned CW = 4;
   localparam int unsigned SW = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      STAGE = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam logic OP_ROL = 1'b0;
   localparam logic OP_SHL = 1'b1;

   // Index of the highest set bit of a shift count; 0 when the count is 0.
   function automatic logic [SW-1:0] msb_index(input logic [CW-1:0] c);
      logic [SW-1:0] m;
      m = '0;
      for (int i = 0; i < int'(CW); i++) begin
         if (c[i]) m = SW'(i);
      end
      return m;
   endfunction

endpackage

// File: rtl/shl_stage.sv
// One barrel-shifter stage: rotate or zero-fill shift left by 2^k when enabled.
module shl_stage
   import shl_pkg::*;
(
   input  logic [DW-1:0] data_i,
   input  logic          op_i,
   input  logic [SW-1:0] k_i,
   input  logic          en_i,
   output logic [DW-1:0] data_o
);

   logic zf;

   // Zero fill for logical shift, MSB wrap for rotate.
   always_comb begin
      zf     = (op_i == OP_SHL);
      data_o = data_i;
      if (en_i) begin
         case (k_i)
            2'd0:    data_o = {data_i[DW-2:0], zf ? 1'b0  : data_i[DW-1]};
            2'd1:    data_o = {data_i[DW-3:0], zf ? 2'b00 : data_i[DW-1 -: 2]};
            2'd2:    data_o = {data_i[DW-5:0], zf ? 4'h0  : data_i[DW-1 -: 4]};
            default: data_o = {data_i[DW-9:0], zf ? 8'h00 : data_i[DW-1 -: 8]};
         endcase
      end
   end

endmodule

// File: rtl/shift_left_seq.sv
// Sequential 16-bit rotate/shift-left unit, one log-stage per clock.
// Optional build macro: SHL_EARLY_EXIT_EN finishes after the highest set count bit.
module shift_left_seq
   import shl_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in,
   input  logic          opsel,
   input  logic [CW-1:0] count,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out
);

   state_e        state_q, state_d;
   logic [SW-1:0] stage_q, stage_d;
   logic [DW-1:0] data_q,  data_d;
   logic          op_q,    op_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic          ov_q,    ov_d;
   logic [DW-1:0] out_q,   out_d;

   logic [DW-1:0] stage_res;
   logic          last_stage;
   logic          accept;

   // Single shared stage, selected by the running stage index.
   shl_stage u_stage (
      .data_i (data_q),
      .op_i   (op_q),
      .k_i    (stage_q),
      .en_i   (cnt_q[stage_q]),
      .data_o (stage_res)
   );

   // Ready only while idle; held low during reset.
   always_comb begin
      in_ready = rst_n && (state_q == IDLE);
      accept   = in_valid && in_ready;
   end

   // Final stage: fixed four stages, or highest set count bit with early exit.
   always_comb begin
`ifdef SHL_EARLY_EXIT_EN
      last_stage = (stage_q == msb_index(cnt_q));
`else
      last_stage = (stage_q == SW'(CW - 1));
`endif
   end

   // Next-state and output logic.
   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      data_d  = data_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      ov_d    = ov_q;
      out_d   = out_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               data_d  = in;
               op_d    = opsel;
               cnt_d   = count;
               stage_d = '0;
               state_d = STAGE;
            end
         end
         STAGE: begin
            data_d = stage_res;
            if (last_stage) begin
               state_d = DONE;
               ov_d    = 1'b1;
               out_d   = stage_res;
            end else begin
               stage_d = stage_q + SW'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
               ov_d    = 1'b0;
               out_d   = '0;
               stage_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
            ov_d    = 1'b0;
            out_d   = '0;
            stage_d = '0;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         stage_q <= '0;
         data_q  <= '0;
         op_q    <= OP_ROL;
         cnt_q   <= '0;
         ov_q    <= 1'b0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         data_q  <= data_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         ov_q    <= ov_d;
         out_q   <= out_d;
      end
   end

   assign out_valid = ov_q;
   assign out       = out_q;

endmodule

// File: tb/tb_shift_left_seq.sv
// Directed bench for shift_left_seq (default build or SHL_EARLY_EXIT_EN).
module tb_shift_left_seq;

   typedef struct {
      logic [15:0] din;
      logic        op;
      logic [3:0]  cnt;
      logic [15:0] exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] din;
   logic        opsel;
   logic [3:0]  count;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] dout;

   int n_cmp = 0;
   int n_err = 0;

   shift_left_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in        (din),
      .opsel     (opsel),
      .count     (count),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (dout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int exp_lat(input logic [3:0] c);
`ifdef SHL_EARLY_EXIT_EN
      int m;
      m = 0;
      for (int i = 0; i < 4; i++) if (c[i]) m = i;
      return m + 1;
`else
      return 4;
`endif
   endfunction

   // Accept one request and wait (bounded) for out_valid; leaves us just after that edge.
   task automatic start_and_wait(input vec_t v, input string tag);
      int  edges;
      bit  busy_ok;
      @(negedge clk);
      chk({tag, " ready_before"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      din      = v.din;
      opsel    = v.op;
      count    = v.cnt;
      @(posedge clk);
      #1;
      busy_ok = (in_ready == 1'b0) && (out_valid == 1'b0) && (dout == 16'h0);
      @(negedge clk);
      in_valid = 1'b0;
      din      = ~v.din;
      opsel    = ~v.op;
      count    = ~v.cnt;
      edges    = 0;
      while (1) begin
         @(posedge clk);
         #1;
         edges++;
         if (out_valid === 1'b1) break;
         if (in_ready !== 1'b0 || dout !== 16'h0) busy_ok = 0;
         if (edges >= 20) break;
      end
      chk({tag, " latency"}, 32'(edges), 32'(exp_lat(v.cnt)));
      chk({tag, " result"}, 32'(dout), 32'(v.exp));
      chk({tag, " busy_ready_out"}, 32'(busy_ok), 32'd1);
      chk({tag, " ready_in_done"}, 32'(in_ready), 32'd0);
   endtask

   vec_t vecs[12];

   initial begin
      vecs[0]  = '{16'h8001, 1'b0, 4'd1,  16'h0003};
      vecs[1]  = '{16'hFFFF, 1'b1, 4'd15, 16'h8000};
      vecs[2]  = '{16'hFFFF, 1'b1, 4'd2,  16'hFFFC};
      vecs[3]  = '{16'h1234, 1'b0, 4'd0,  16'h1234};
      vecs[4]  = '{16'h00F0, 1'b1, 4'd4,  16'h0F00};
      vecs[5]  = '{16'h1234, 1'b0, 4'd4,  16'h2341};
      vecs[6]  = '{16'h1234, 1'b0, 4'd12, 16'h4123};
      vecs[7]  = '{16'hABCD, 1'b0, 4'd8,  16'hCDAB};
      vecs[8]  = '{16'h8421, 1'b1, 4'd3,  16'h2108};
      vecs[9]  = '{16'h0001, 1'b1, 4'd15, 16'h8000};
      vecs[10] = '{16'hC003, 1'b0, 4'd15, 16'hE001};
      vecs[11] = '{16'h5A5A, 1'b1, 4'd1,  16'hB4B4};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      din       = 16'h0;
      opsel     = 1'b0;
      count     = 4'd0;
      out_ready = 1'b1;
      #1;
      chk("reset in_ready", 32'(in_ready), 32'd0);
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset out", 32'(dout), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("release in_ready", 32'(in_ready), 32'd1);

      // Back-to-back requests with out_ready tied high.
      for (int i = 0; i < 12; i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         start_and_wait(vecs[i], tag);
         @(posedge clk);
         #1;
         chk({tag, " handoff"}, {29'd0, out_valid, in_ready, |dout}, {29'd0, 1'b0, 1'b1, 1'b0});
      end

      // Result held while consumer stalls; in_valid pulses are ignored.
      out_ready = 1'b0;
      start_and_wait(vecs[4], "hold");
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         in_valid = c[0];
         din      = 16'hDEAD;
         opsel    = 1'b0;
         count    = 4'd5;
         @(posedge clk);
         #1;
         chk($sformatf("hold c%0d", c), {14'd0, out_valid, in_ready, dout}, {14'd0, 1'b1, 1'b0, 16'h0F00});
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("hold release", {29'd0, out_valid, in_ready, |dout}, {29'd0, 1'b0, 1'b1, 1'b0});
      begin
         bit seen;
         seen = 0;
         repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1;
         end
         chk("hold no_queue", 32'(seen), 32'd0);
      end

      // Reset in the middle of an operation.
      @(negedge clk);
      in_valid = 1'b1;
      din      = 16'hABCD;
      opsel    = 1'b0;
      count    = 4'd8;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midreset outs", {15'd0, out_valid, in_ready, dout}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("midreset in_ready", 32'(in_ready), 32'd1);
      begin
         bit seen;
         seen = 0;
         repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid || dout != 16'h0) seen = 1;
         end
         chk("midreset no_pulse", 32'(seen), 32'd0);
      end

      // Function still works after the aborted request.
      start_and_wait(vecs[0], "post_reset");
      @(posedge clk);
      #1;
      chk("post_reset handoff", {29'd0, out_valid, in_ready, |dout}, {29'd0, 1'b0, 1'b1, 1'b0});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/shift_left_seq.md
SHIFT_LEFT_SEQ -- requirements
Module: shift_left_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Ports SHALL be as follows:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request present
- in_ready  output  1  block can accept a request
- in  input  16  operand
- opsel  input  1  0 = rotate left, 1 = logical shift left (zero fill)
- count  input  4  shift amount, 0..15
- out_valid  output  1  result present
- out_ready  input  1  consumer takes result
- out  output  16  result

Function
REQ-003 Accept SHALL occur on a rising edge with in_valid=1 and in_ready=1. On that edge the block SHALL latch in, opsel and count into internal registers.
REQ-004 The state machine SHALL have the states IDLE, STAGE and DONE. A 2-bit stage index SHALL run 0..3.
REQ-005 in_ready SHALL be 1 only in IDLE and 0 in STAGE and DONE.
REQ-006 On accept, the block SHALL go from IDLE to STAGE with the stage index set to 0.
REQ-007 Each clock edge in STAGE SHALL apply stage k (k = stage index): shift or rotate left by 2^k when count[k]=1, pass the data unchanged when count[k]=0.
REQ-008 After stage 3 the block SHALL go to DONE.
REQ-009 For each stage, rotate SHALL wrap the 2^k MSBs into the 2^k LSBs. Logical shift SHALL fill those LSBs with 0.
REQ-010 Without the macro of REQ-021, out_valid SHALL go high exactly 4 clock edges after the accept edge, for every count value.
REQ-011 In DONE, out_valid=1 and out SHALL hold the final result stable until out_ready=1.
REQ-012 An edge in DONE with out_ready=1 SHALL return the block to IDLE and set out_valid=0. The next accept is possible on the following edge at the earliest (no same-cycle turnaround).
REQ-013 out SHALL equal (in << count) for logical shift, or rotl(in, count) for rotate, truncated to 16 bits.
REQ-014 count=0 SHALL return in unchanged.
REQ-015 Changes on in, opsel and count after accept SHALL NOT affect the result in flight.
REQ-016 in_valid asserted outside IDLE SHALL be ignored, with no queuing.
REQ-017 out SHALL be 0x0000 whenever out_valid=0.

Reset
REQ-018 rst_n=0 SHALL, asynchronously and at any state, force: state IDLE, stage index 0, data register 0x0000, out_valid=0, out=0x0000.
REQ-019 The release value of in_ready SHALL be 1. in_ready is held 0 while rst_n=0.
REQ-020 A reset mid-operation SHALL discard the in-flight request, with no out_valid pulse afterwards.

Configuration
REQ-021 The macro SHL_EARLY_EXIT_EN SHALL control early exit.
- Defined: the block SHALL enter DONE on the edge that applies the highest set bit of count. Latency = 1 + msb_index(count) edges. count=0 SHALL enter DONE on the first edge after accept, with data unchanged.
- Undefined: fixed 4-edge latency per REQ-010.
- Results SHALL be identical in both builds.

Structure
REQ-022 A shared package shl_pkg SHALL hold:
- the state enum (IDLE, STAGE, DONE)
- the opsel constants OP_ROL=0 and OP_SHL=1
- the data width constant DW=16
REQ-023 One combinational sub-module shl_stage SHALL implement a single stage. It takes data[15:0], opsel, amount-select k[1:0] and enable, and returns data[15:0]. The top SHALL instantiate it once and reuse it across stages.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- in=0x8001, opsel=0, count=1 -> out=0x0003. out_valid rises 4 edges after accept (macro undefined).
- in=0xFFFF, opsel=1, count=15 -> out=0x8000. With SHL_EARLY_EXIT_EN: latency 4 edges. count=2: latency 2 edges.
- in=0x1234, opsel=0, count=0 -> out=0x1234. Latency 4 edges, or 1 edge with the macro.
- in=0x00F0, opsel=1, count=4 -> out=0x0F00. out_ready held 0 for 5 cycles -> out stable and out_valid=1 throughout. in_valid pulses during that time are ignored.
- in=0xABCD, opsel=0, count=8 accepted, then rst_n=0 after stage 1 -> out_valid never asserts. Outputs return to 0 immediately. in_ready=1 after release.
- Back-to-back accepts with out_ready tied to 1 -> in_ready low from accept until the edge after the DONE handoff. Exactly one out_valid cycle per request, and results match REQ-013.
